// File: rtl/icon_tx_queue_if.sv
// Shared channel types and the ALU-to-interconnect handshake bundle
// seen by the per-unit transmit queue.
package icon_pkg;
  localparam int LOG2_NUM_EXEC_UNITS = 2;

  typedef struct packed {
    logic [LOG2_NUM_EXEC_UNITS-1:0] euidx;
    logic [5:0]                     reg_idx;
  } type_exec_unit_addr;

  typedef logic [31:0] type_exec_unit_data;

  typedef struct packed {
    type_exec_unit_data opd_data;
    type_exec_unit_addr opd_addr;
    logic               opd_valid;
  } type_alu_channel_tx;

  typedef struct packed {
    type_exec_unit_addr addr;
    type_exec_unit_data data;
    logic               valid;
  } type_icon_tx_channel;

  typedef struct packed {
    logic success;
  } type_icon_rx_channel;
endpackage

interface icon_tx_queue_if #(
  parameter int LOG2_DEPTH = 2
);
  import icon_pkg::*;

  logic                i_flush;
  type_alu_channel_tx  i_alu_tx;
  logic                o_alu_ready;
  type_icon_tx_channel o_icon_tx;
  type_icon_rx_channel i_icon_rx;
  logic [LOG2_DEPTH:0] o_count;

  // slave is the queue itself; master is the ALU/interconnect side
  modport slave (
    input  i_flush, i_alu_tx, i_icon_rx,
    output o_alu_ready, o_icon_tx, o_count
  );
  modport master (
    output i_flush, i_alu_tx, i_icon_rx,
    input  o_alu_ready, o_icon_tx, o_count
  );
endinterface

// File: rtl/icon_tx_queue.sv
// Circular FIFO holding ALU results bound for foreign execution units until
// the interconnect accepts the head entry; results for the owning unit are dropped.
module icon_tx_queue
  import icon_pkg::*;
#(
  parameter int                             LOG2_DEPTH = 2,
  parameter logic [LOG2_NUM_EXEC_UNITS-1:0] EU_IDX     = LOG2_NUM_EXEC_UNITS'(0)
) (
  input  logic          clk,
  input  logic          reset,
  icon_tx_queue_if.slave q
);

  localparam int DEPTH = 32'd1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0]   DEPTH_C = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   CNT_ONE = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE = (LOG2_DEPTH)'(1);

  typedef struct packed {
    type_exec_unit_addr addr;
    type_exec_unit_data data;
  } entry_t;

  entry_t                mem_r [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_r;
  logic [LOG2_DEPTH-1:0] rd_ptr_r;
  logic [LOG2_DEPTH:0]   count_r;
  logic [LOG2_DEPTH:0]   count_nxt_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  local_s;
  logic                  pop_s;
  logic                  push_s;

  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == {(LOG2_DEPTH+1){1'b0}});
  assign local_s = (q.i_alu_tx.opd_addr.euidx == EU_IDX);
  assign pop_s   = !empty_s && q.i_icon_rx.success;
  // A full queue still accepts when the head leaves in the same cycle
  assign q.o_alu_ready = !full_s || pop_s;
  assign push_s  = q.i_alu_tx.opd_valid && !local_s && q.o_alu_ready;
  assign q.o_count = count_r;

  // Occupancy next-state from the push/pop pair
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Head presentation, forced to zero while the queue is empty
  always_comb begin
    q.o_icon_tx = '0;
    if (!empty_s) begin
      q.o_icon_tx.addr  = mem_r[rd_ptr_r].addr;
      q.o_icon_tx.data  = mem_r[rd_ptr_r].data;
      q.o_icon_tx.valid = 1'b1;
    end else begin
      q.o_icon_tx = '0;
    end
  end

  // Pointer and occupancy state; flush wins over any simultaneous push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {LOG2_DEPTH{1'b0}};
      rd_ptr_r <= {LOG2_DEPTH{1'b0}};
      count_r  <= {(LOG2_DEPTH+1){1'b0}};
    end else if (q.i_flush) begin
      wr_ptr_r <= {LOG2_DEPTH{1'b0}};
      rd_ptr_r <= {LOG2_DEPTH{1'b0}};
      count_r  <= {(LOG2_DEPTH+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; contents are don't-care outside the live window
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= '{addr: q.i_alu_tx.opd_addr, data: q.i_alu_tx.opd_data};
    end
  end

endmodule

// File: tb/tb_icon_tx_queue.sv
// Scoreboard bench for icon_tx_queue: accepted pushes are queued as expected
// head entries and compared whenever the interconnect side consumes one.
module tb_icon_tx_queue;
  import icon_pkg::*;

  localparam logic [1:0] EU  = 2'd0;
  localparam logic [1:0] FOR = 2'd1;

  typedef struct packed {
    type_exec_unit_addr addr;
    type_exec_unit_data data;
  } ent_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  ent_t sb[$];

  icon_tx_queue_if #(.LOG2_DEPTH(2)) bus ();

  icon_tx_queue #(.LOG2_DEPTH(2), .EU_IDX(EU)) dut (
    .clk  (clk),
    .reset(reset),
    .q    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] eu, input logic [31:0] d,
                       input logic s, input logic f);
    bus.i_alu_tx.opd_valid        = v;
    bus.i_alu_tx.opd_addr.euidx   = eu;
    bus.i_alu_tx.opd_addr.reg_idx = d[5:0];
    bus.i_alu_tx.opd_data         = d;
    bus.i_icon_rx.success         = s;
    bus.i_flush                   = f;
    #3;
  endtask

  // Compare the head against the scoreboard, update the model, advance one edge
  task automatic step();
    logic was_full;
    logic popped;
    ent_t e;
    was_full = (sb.size() == 4);
    popped   = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      if (bus.o_icon_tx.valid !== 1'b1 || bus.o_icon_tx.data !== sb[0].data ||
          bus.o_icon_tx.addr !== sb[0].addr) begin
        errors++;
        $display("FAIL head: got valid=%0b addr=%h data=%h, want valid=1 addr=%h data=%h",
                 bus.o_icon_tx.valid, bus.o_icon_tx.addr, bus.o_icon_tx.data,
                 sb[0].addr, sb[0].data);
      end
      if (bus.i_icon_rx.success) begin
        void'(sb.pop_front());
        popped = 1'b1;
      end
    end else begin
      if (bus.o_icon_tx !== '0) begin
        errors++;
        $display("FAIL empty_head: got %h, want 0", bus.o_icon_tx);
      end
    end
    if (bus.i_alu_tx.opd_valid && bus.i_alu_tx.opd_addr.euidx != EU && (!was_full || popped)) begin
      e.addr = bus.i_alu_tx.opd_addr;
      e.data = bus.i_alu_tx.opd_data;
      sb.push_back(e);
    end
    if (bus.i_flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.o_icon_tx !== '0 || bus.o_count !== 3'd0 || bus.o_alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init: got tx=%h count=%0d ready=%0b, want 0/0/1",
               bus.o_icon_tx, bus.o_count, bus.o_alu_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, FOR, 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, FOR, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d, want 3", bus.o_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.o_icon_tx !== '0 || bus.o_count !== 3'd0 || bus.o_alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: got tx=%h count=%0d ready=%0b, want 0/0/1",
               bus.o_icon_tx, bus.o_count, bus.o_alu_ready);
    end
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b1, FOR, 32'h11, 1'b0, 1'b0);
    step();
    drive(1'b0, FOR, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_count: got %0d, want 1", bus.o_count);
    end
    step();
    drive(1'b0, FOR, 32'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, FOR, 32'hA0 + 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 2'd3, 32'hA9, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd4 || bus.o_alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got count=%0d ready=%0b, want 4/0", bus.o_count, bus.o_alu_ready);
    end
    step();
    step();
    drive(1'b0, FOR, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd4) begin
      errors++;
      $display("FAIL fifth_rejected: got count=%0d, want 4", bus.o_count);
    end
  endtask

  task automatic test_local_filter();
    drive(1'b1, EU, 32'h55, 1'b0, 1'b0);
    step();
    drive(1'b0, FOR, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd4) begin
      errors++;
      $display("FAIL local_count: got %0d, want 4", bus.o_count);
    end
  endtask

  task automatic test_full_push_pop();
    drive(1'b1, FOR, 32'hA4, 1'b1, 1'b0);
    checks++;
    if (bus.o_alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop_ready: got %0b, want 1", bus.o_alu_ready);
    end
    step();
    drive(1'b0, FOR, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd4) begin
      errors++;
      $display("FAIL full_pushpop_count: got %0d, want 4", bus.o_count);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, FOR, 32'd0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, FOR, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain_count: got %0d, want 0 (model %0d)", bus.o_count, sb.size());
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, FOR, 32'(i), 1'b1, 1'b0);
      if (i > 0) begin
        checks++;
        if (bus.o_count !== 3'd1) begin
          errors++;
          $display("FAIL stream_count[%0d]: got %0d, want 1", i, bus.o_count);
        end
      end
      step();
    end
    drive(1'b0, FOR, 32'd0, 1'b1, 1'b0);
    step();
    drive(1'b0, FOR, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd0) begin
      errors++;
      $display("FAIL stream_end: got %0d, want 0", bus.o_count);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, FOR, 32'h21, 1'b0, 1'b0);
    step();
    drive(1'b1, FOR, 32'h22, 1'b0, 1'b0);
    step();
    drive(1'b1, FOR, 32'h23, 1'b1, 1'b1);
    checks++;
    if (bus.o_count !== 3'd2) begin
      errors++;
      $display("FAIL pre_flush_count: got %0d, want 2", bus.o_count);
    end
    step();
    drive(1'b0, FOR, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd0 || bus.o_icon_tx.valid !== 1'b0) begin
      errors++;
      $display("FAIL flush: got count=%0d valid=%0b, want 0/0", bus.o_count, bus.o_icon_tx.valid);
    end
    step();
    drive(1'b1, 2'd2, 32'h77, 1'b0, 1'b0);
    step();
    drive(1'b0, FOR, 32'd0, 1'b1, 1'b0);
    checks++;
    if (bus.o_count !== 3'd1) begin
      errors++;
      $display("FAIL post_flush_count: got %0d, want 1", bus.o_count);
    end
    step();
    drive(1'b0, FOR, 32'd0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.i_flush       = 1'b0;
    bus.i_alu_tx      = '0;
    bus.i_icon_rx     = '0;
    #2;
    test_reset();
    test_fill();
    test_local_filter();
    test_full_push_pop();
    test_stream();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icon_tx_queue.md
# icon_tx_queue

Per-execution-unit result transmit queue between an ALU's `type_alu_channel_tx` output and its interconnect `type_icon_tx_channel`. It buffers ALU results destined for foreign execution units and presents them in order to the interconnect, holding each head entry until the interconnect reports `success`. Results addressed to the owning unit are filtered out, since they are written locally. Storage is a small circular FIFO with a registered occupancy count.

## Interface
Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- `LOG2_DEPTH`, 2: log2 of the number of FIFO entries (depth 4).
- `EU_IDX`, 0: index of the owning execution unit, `LOG2_NUM_EXEC_UNITS` bits wide.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous active-high reset.
- `i_flush`  in  1  synchronous clear of all entries.
- `i_alu_tx`  in  `$bits(type_alu_channel_tx)`  ALU result: `opd_data`, `opd_addr`, `opd_valid`.
- `o_alu_ready`  out  1  queue can accept a result this cycle.
- `o_icon_tx`  out  `$bits(type_icon_tx_channel)`  head entry as `addr`, `data`, `valid`.
- `i_icon_rx`  in  `$bits(type_icon_rx_channel)`  `success` = head accepted this cycle.
- `o_count`  out  `LOG2_DEPTH+1`  current occupancy, 0..2^LOG2_DEPTH.

## Operation
State:
- Entry array of {`type_exec_unit_addr`, `type_exec_unit_data`}.
- `wr_ptr` and `rd_ptr`, each `LOG2_DEPTH` bits, wrapping modulo depth.
- `count`, `LOG2_DEPTH+1` bits.

Derived signals:
- `full` = (count == 2^LOG2_DEPTH).
- `empty` = (count == 0).
- `local` = (`i_alu_tx.opd_addr.euidx` == EU_IDX).
- `pop` = `o_icon_tx.valid` && `i_icon_rx.success`.
- `push` = `i_alu_tx.opd_valid` && !`local` && `o_alu_ready`.

Behaviour:
- `o_alu_ready` = !full || pop (combinational). A full queue accepts a push in the same cycle it pops.
- Local results (`local`=1) are discarded whatever the ready state. They are never enqueued and never stall.
- On `push`: write the entry at `wr_ptr`, then `wr_ptr`++.
- On `pop`: `rd_ptr`++.
- Count update: push only → +1; pop only → -1; both → unchanged.
- `o_icon_tx.valid` = !empty.
- `o_icon_tx.addr` and `o_icon_tx.data` are read from entry[`rd_ptr`]. They are zero when empty.
- `success` while empty is ignored.
- Ordering: strict FIFO. There is no reordering by destination.
- `i_flush`:
  - sets `wr_ptr`=`rd_ptr`=`count`=0 next cycle;
  - overrides a simultaneous push and pop;
  - entry contents need not be cleared.
- Mid-operation `reset`: state is lost immediately and outputs go to their reset values asynchronously.

## Timing
Reset values:
- `o_icon_tx` = all zero (valid=0).
- `o_count` = 0.
- `o_alu_ready` = 1.

Latency:
- A push at edge N makes the entry visible on `o_icon_tx` from after edge N with valid=1.
- There is no same-cycle bypass of an empty queue: minimum latency is 1 cycle.

Handshake:
- While valid=1 and success=0, the head `addr` and `data` hold stable.
- `success` is sampled in the same cycle as valid. The next entry, or valid=0, appears after that edge.
- Throughput is one push and one pop per cycle in steady state.

Counter and pointers:
- `o_count` is registered and reflects the push/pop of the previous edge.
- Pointers wrap from 2^LOG2_DEPTH-1 to 0 with no bubble.

## Test plan
- **Reset:** assert `reset` mid-stream with count=3 → outputs immediately valid=0, count=0, ready=1. After deassert, the first push of data 0x11 appears at the head one cycle later.
- **Fill and backpressure:** push 4 foreign results (euidx≠EU_IDX, data 0xA0..0xA3) with success=0 → count=4, ready=0. A fifth result is not accepted, and the head holds 0xA0 throughout.
- **Full simultaneous push/pop:** at count=4, assert success together with a push of 0xA4 → ready=1 that cycle and count stays 4. The heads then drain in order 0xA1, 0xA2, 0xA3, 0xA4.
- **Local filter:** push `opd_valid`=1 with euidx==EU_IDX and data 0x55 while full → no stall and count unchanged. 0x55 never appears on `o_icon_tx`.
- **Wrap and streaming:** push and pop every cycle with success=1 for 10 results (0x00..0x09) → each emerges exactly 1 cycle after its push, with count steady at 1 and in-order across pointer wrap.
- **Flush:** at count=2, assert `i_flush` together with push and success → next cycle count=0 and valid=0. A following push of 0x77 is the next head.
